// File: rtl/display_share_arbiter.sv
// display_share_arbiter
//   Round-robin time-sharing of one multiplexed seven-segment display between
//   NUM_SOURCES requesters. The owner keeps the display for DWELL_CYCLES
//   cycles per slice. It can extend its slice with lock. It yields
//   immediately when it drops its request.
// Ports:
//   clock, reset   single clock domain; synchronous active-high reset
//   request        per-source display request
//   lock           per-source "keep the display past dwell expiry" (owner only)
//   sourceData     packed images, source i at [i*NUM_DIGITS*4 +: NUM_DIGITS*4]
//   sourcePoints   packed point masks, source i at [i*NUM_DIGITS +: NUM_DIGITS]
//   grant          registered one-hot owner, zero when idle
//   data           registered owner image, zero when idle
//   pointEnable    registered owner point mask, zero when idle
//   active         registered, high while a source owns the display
module display_share_arbiter #(
  parameter int NUM_SOURCES  = 4,
  parameter int NUM_DIGITS   = 8,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int DWELL_WIDTH  = 27
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_SOURCES-1:0]             request,
  input  logic [NUM_SOURCES-1:0]             lock,
  input  logic [NUM_SOURCES*NUM_DIGITS*4-1:0] sourceData,
  input  logic [NUM_SOURCES*NUM_DIGITS-1:0]  sourcePoints,
  output logic [NUM_SOURCES-1:0]             grant,
  output logic [NUM_DIGITS*4-1:0]            data,
  output logic [NUM_DIGITS-1:0]              pointEnable,
  output logic                               active
);

  localparam int IW = $clog2(NUM_SOURCES);
  localparam int DW = NUM_DIGITS * 4;
  localparam logic [DWELL_WIDTH-1:0] RELOAD = DWELL_WIDTH'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0]          LAST0  = IW'(NUM_SOURCES - 1);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t                 st, st_n;
  logic [IW-1:0]          g, g_n, last, last_n, pick;
  logic [DWELL_WIDTH-1:0] cnt, cnt_n;
  logic [NUM_SOURCES-1:0] cand, grant_n;
  logic [DW-1:0]          data_n;
  logic [NUM_DIGITS-1:0]  pts_n;
  logic                   found;

  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= IDLE;
      g           <= '0;
      cnt         <= '0;
      last        <= LAST0;
      grant       <= '0;
      data        <= '0;
      pointEnable <= '0;
      active      <= 1'b0;
    end else begin
      st          <= st_n;
      g           <= g_n;
      cnt         <= cnt_n;
      last        <= last_n;
      grant       <= grant_n;
      data        <= data_n;
      pointEnable <= pts_n;
      active      <= (st_n == DWELL);
    end
  end

  always_comb begin
    int idx;
    st_n   = st;
    g_n    = g;
    cnt_n  = cnt;
    last_n = last;
    found  = 1'b0;
    pick   = '0;
    idx    = 0;

    // The owner is never a candidate. It either released (its request is low)
    // or its slice expired and a contested owner must yield. The uncontested
    // case falls back to a reload below.
    cand = request;
    if (st == DWELL) cand[g] = 1'b0;

    // Scan last+1, last+2, ... so the most recent owner comes last.
    for (int k = 1; k <= NUM_SOURCES; k++) begin
      idx = (int'(last) + k) % NUM_SOURCES;
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end

    case (st)
      IDLE: begin
        if (found) begin
          st_n   = DWELL;
          g_n    = pick;
          cnt_n  = RELOAD;
          last_n = pick;
        end
      end
      default: begin
        if (!request[g]) begin
          if (found) begin
            g_n    = pick;
            cnt_n  = RELOAD;
            last_n = pick;
          end else begin
            st_n  = IDLE;
            cnt_n = '0;
          end
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (lock[g] || !found) begin
          cnt_n = RELOAD;
        end else begin
          g_n    = pick;
          cnt_n  = RELOAD;
          last_n = pick;
        end
      end
    endcase

    // Outputs follow the next owner, so grant and image change on one edge.
    grant_n = '0;
    data_n  = '0;
    pts_n   = '0;
    if (st_n == DWELL) begin
      grant_n = NUM_SOURCES'(1) << g_n;
      data_n  = sourceData[int'(g_n)*DW +: DW];
      pts_n   = sourcePoints[int'(g_n)*NUM_DIGITS +: NUM_DIGITS];
    end
  end

endmodule

// File: tb/tb_display_share_arbiter.sv
module tb_display_share_arbiter;

  localparam int NS = 4;
  localparam int ND = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [NS-1:0]     request, lock;
  logic [NS*ND*4-1:0] sourceData;
  logic [NS*ND-1:0]  sourcePoints;
  logic [NS-1:0]     grant;
  logic [ND*4-1:0]   data;
  logic [ND-1:0]     pointEnable;
  logic              active;

  logic [31:0] img [NS];
  logic [7:0]  pts [NS];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      sourceData[i*32 +: 32]  = img[i];
      sourcePoints[i*8 +: 8]  = pts[i];
    end
  end

  display_share_arbiter #(
    .NUM_SOURCES(NS), .NUM_DIGITS(ND), .DWELL_CYCLES(4), .DWELL_WIDTH(3)
  ) dut (
    .clock(clock), .reset(reset), .request(request), .lock(lock),
    .sourceData(sourceData), .sourcePoints(sourcePoints),
    .grant(grant), .data(data), .pointEnable(pointEnable), .active(active)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] lck;
    logic [3:0] g;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] lck,
                     input logic [3:0] g, input int n);
    vec_t v;
    v.rst = rst; v.req = req; v.lck = lck; v.g = g;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference image for an expected one-hot grant (zero when idle).
  function automatic logic [31:0] exp_img(input logic [3:0] g);
    exp_img = '0;
    for (int i = 0; i < NS; i++) if (g[i]) exp_img = 32'h1111_1111 * (i + 1);
  endfunction

  function automatic logic [7:0] exp_pts(input logic [3:0] g);
    exp_pts = '0;
    for (int i = 0; i < NS; i++) if (g[i]) exp_pts = 8'h01 << i;
  endfunction

  task automatic step_check(input vec_t v, input int n);
    string s;
    reset = v.rst; request = v.req; lock = v.lck;
    @(posedge clock); #1;
    s = $sformatf("v%0d", n);
    chk32({s, ".grant"}, 32'(grant), 32'(v.g));
    chk32({s, ".data"}, data, exp_img(v.g));
    chk32({s, ".points"}, 32'(pointEnable), 32'(exp_pts(v.g)));
    chk32({s, ".active"}, 32'(active), 32'(v.g != 4'b0));
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      img[i] = 32'h1111_1111 * (i + 1);
      pts[i] = 8'h01 << i;
    end
    reset = 1'b1; request = '0; lock = '0;

    // reset wins over requests
    add(1, 4'b1111, 4'b0000, 4'b0000, 2);
    // single request, one-cycle latency, then full-contention rotation
    add(0, 4'b0001, 4'b0000, 4'b0001, 1);
    add(0, 4'b1111, 4'b0000, 4'b0001, 3);
    add(0, 4'b1111, 4'b0000, 4'b0010, 4);
    add(0, 4'b1111, 4'b0000, 4'b0100, 4);
    add(0, 4'b1111, 4'b0000, 4'b1000, 4);
    add(0, 4'b1111, 4'b0000, 4'b0001, 4);
    add(0, 4'b1111, 4'b0000, 4'b0010, 2);
    // early release to 0100 with a fresh 4-cycle slice, then on to 0001
    add(0, 4'b0101, 4'b0000, 4'b0100, 4);
    add(0, 4'b0101, 4'b0000, 4'b0001, 1);
    // early release to idle
    add(0, 4'b0010, 4'b0000, 4'b0010, 2);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2);
    // lock holds 0100 well past its slice; unlock yields at slice end
    add(0, 4'b1111, 4'b0100, 4'b0100, 21);
    add(0, 4'b1111, 4'b0000, 4'b0100, 3);
    add(0, 4'b1111, 4'b0000, 4'b1000, 1);
    // owner 3 releases; lone requester keeps display with no gap
    add(0, 4'b0100, 4'b0000, 4'b0100, 13);
    // reset mid-dwell, then source 0 has top priority again
    add(0, 4'b0010, 4'b0000, 4'b0010, 2);
    add(1, 4'b1111, 4'b0000, 4'b0000, 1);
    add(0, 4'b1111, 4'b0000, 4'b0001, 1);

    foreach (vecs[i]) step_check(vecs[i], i);

    // owner image and points change mid-dwell: visible after the next edge
    img[0] = 32'hDEAD_BEEF; pts[0] = 8'hA5;
    request = 4'b1111; lock = '0; reset = 1'b0;
    @(posedge clock); #1;
    chk32("img.grant", 32'(grant), 32'h1);
    chk32("img.data", data, 32'hDEAD_BEEF);
    chk32("img.points", 32'(pointEnable), 32'hA5);
    // a non-owner image change is not shown
    img[1] = 32'h0BAD_F00D;
    @(posedge clock); #1;
    chk32("img.nonowner", data, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_share_arbiter.md
# display_share_arbiter

Time-shares one multiplexed seven-segment display between several requesting sources. Each source presents a full display image (hex nibbles plus decimal points) and a request. A round-robin scheduler grants the display to one source at a time for a programmable dwell period. The block drives the `data` / `pointEnable` inputs of the seven-segment controller, plus an `active` flag that board-level logic uses to blank the digits when no source holds the display.

## Interface
- `NUM_SOURCES`, 4: number of requesting sources (≥2)
- `NUM_DIGITS`, 8: digits per image; must match the downstream seven-segment controller
- `DWELL_CYCLES`, 100_000_000: clock cycles per grant slice (1 s at 100 MHz); ≥1
- `DWELL_WIDTH`, 27: counter width; 2^DWELL_WIDTH > DWELL_CYCLES-1

Ports:
- `clock`  in  1  system clock, single clock domain
- `reset`  in  1  synchronous, active-high reset
- `request`  in  NUM_SOURCES  source i wants the display while high
- `lock`  in  NUM_SOURCES  source i asks to keep the display past dwell expiry
- `sourceData`  in  NUM_SOURCES*NUM_DIGITS*4  image of source i at `[i*NUM_DIGITS*4 +: NUM_DIGITS*4]`
- `sourcePoints`  in  NUM_SOURCES*NUM_DIGITS  point mask of source i at `[i*NUM_DIGITS +: NUM_DIGITS]`
- `grant`  out  NUM_SOURCES  registered one-hot owner, or all-zero
- `data`  out  NUM_DIGITS*4  registered image of the owner; 0 when idle
- `pointEnable`  out  NUM_DIGITS  registered point mask of the owner; 0 when idle
- `active`  out  1  registered; high iff `grant` != 0

## Operation
- States:
  - **IDLE**: no owner.
  - **DWELL**: owner `g`, with dwell counter `cnt`.
- **Round-robin pick:** choose the first requesting index scanning `last+1, last+2, …` (mod NUM_SOURCES), where `last` is the most recent owner. After reset, `last = NUM_SOURCES-1`, so source 0 has top priority.
- **IDLE:**
  - If any `request` bit is set: pick a winner, grant it, load `cnt = DWELL_CYCLES-1`, go to DWELL.
  - Otherwise stay in IDLE.
- **DWELL, evaluated in priority order each cycle:**
  1. `request[g]` low: release immediately. Re-pick among the remaining requests; grant the winner with a fresh `cnt`, or go to IDLE if none.
  2. `cnt != 0`: decrement `cnt`.
  3. `cnt == 0` and `lock[g]`: reload `cnt` and keep `g`.
  4. `cnt == 0`, no lock:
     - Another source requesting: switch to the round-robin winner. `g` itself is excluded this time, so a contested owner always yields.
     - Otherwise: reload `cnt` and keep `g`. There is no gap in the grant.
- `last` updates whenever a new owner is granted.
- **Outputs:**
  - `data` and `pointEnable` are re-registered every cycle from the owner's slice, so owner image changes propagate during a dwell.
  - In IDLE, outputs are zero.
- `lock` is ignored for non-owners and does not affect arbitration order.
- Only `grant` is one-hot; there is never more than one owner.

## Timing
- Reset values (the edge where `reset` is high): `grant=0`, `data=0`, `pointEnable=0`, `active=0`, state IDLE, `cnt=0`, `last=NUM_SOURCES-1`.
- `reset` takes priority over every other input in the same cycle, including mid-dwell.
- Request-to-grant latency: `request` high before edge t → `grant`, `active`, `data`, `pointEnable` valid after edge t (one cycle).
- Slice length: exactly DWELL_CYCLES cycles when contested and unlocked. The owner switches on the edge following the cycle with `cnt==0`.
- Release latency: owner's `request` low before edge t → new owner, or zeros, after edge t.
- Source image latency: `sourceData` of the owner at cycle t appears on `data` after edge t.
- DWELL_CYCLES=1 with contention: the owner rotates every cycle.
- `grant` and `data`/`pointEnable` always change on the same edge. There is no cycle where `grant` names one source and `data` shows another.

## Test plan
All scenarios use NUM_SOURCES=4, NUM_DIGITS=8, DWELL_CYCLES=4, `sourceData[i]` = 32'h1111_1111*(i+1), `sourcePoints[i]` = 8'h01<<i.

- **Reset, single request:** release reset, `request=0001` → one cycle later `grant=0001`, `data=32'h1111_1111`, `pointEnable=8'h01`, `active=1`.
- **Full contention:** hold `request=1111` → grant sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001… cycles; `data` tracks each owner on the same edge.
- **Early release:** owner 0010 drops `request[1]` at its second dwell cycle with `request=0101` → next edge `grant=0100` with fresh 4-cycle slice. Repeat with `request=0000` → `grant=0`, `data=0`, `active=0`.
- **Lock:** `request=1111`, `lock=0100` → once granted, 0100 holds for ≥16 cycles. Drop `lock[2]` → owner switches to 1000 at the end of the current slice.
- **Uncontested expiry:** `request=0100` only, held 12 cycles → `grant=0100` continuously, `active` never drops.
- **Reset mid-dwell:** assert `reset` during owner 0010's slice → next edge all outputs zero. Release with `request=1111` → `grant=0001` first.
